// File: rtl/dcache_state_dumper.sv
// Walks every set of the L1 DCache tag and data arrays through their RW0 read ports
// and streams tag words and data rows out as records over a valid/ready interface.
module dcache_state_dumper #(
  parameter int SETS      = 64,
  parameter int WAYS      = 4,
  parameter int TAG_BITS  = 22,
  parameter int ROW_BYTES = 8,
  parameter int ROWS      = 8,
  localparam int SW  = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int AW  = (SETS * ROWS > 1) ? $clog2(SETS * ROWS) : 1,
  localparam int DW  = ROW_BYTES * 8,
  localparam int TW  = WAYS * TAG_BITS,
  localparam int DRW = WAYS * DW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           tag_en,
  output logic [SW-1:0]  tag_addr,
  input  logic [TW-1:0]  tag_rdata,
  output logic           data_en,
  output logic [AW-1:0]  data_addr,
  input  logic [DRW-1:0] data_rdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_is_tag,
  output logic [SW-1:0]  out_set,
  output logic [WW-1:0]  out_way,
  output logic [RW-1:0]  out_row,
  output logic [DW-1:0]  out_data
);

  typedef enum logic [2:0] {
    IDLE, TAG_REQ, TAG_RSP, TAG_EMIT, DATA_REQ, DATA_RSP, DATA_EMIT, DONE
  } state_t;

  state_t         state;
  logic [SW-1:0]  set_q;
  logic [WW-1:0]  way_q;
  logic [RW-1:0]  row_q;
  logic [TW-1:0]  tag_buf;
  logic [DRW-1:0] data_buf;

  logic          fire, last_way, last_row, last_set;
  logic [WW-1:0] way_nx;

  assign fire     = out_valid & out_ready;
  assign last_way = (way_q == WW'(WAYS - 1));
  assign last_row = (row_q == RW'(ROWS - 1));
  assign last_set = (set_q == SW'(SETS - 1));
  assign way_nx   = way_q + WW'(1);

  function automatic logic [AW-1:0] row_addr(input logic [SW-1:0] s, input logic [RW-1:0] r);
    return AW'(s) * AW'(ROWS) + AW'(r);
  endfunction

  function automatic logic [DW-1:0] tag_field(input logic [TW-1:0] buf_w, input logic [WW-1:0] w);
    return DW'(buf_w[w*TAG_BITS +: TAG_BITS]);
  endfunction

  // Outputs are registered: each transition loads the values for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      set_q      <= '0;
      way_q      <= '0;
      row_q      <= '0;
      tag_buf    <= '0;
      data_buf   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tag_en     <= 1'b0;
      tag_addr   <= '0;
      data_en    <= 1'b0;
      data_addr  <= '0;
      out_valid  <= 1'b0;
      out_is_tag <= 1'b0;
      out_set    <= '0;
      out_way    <= '0;
      out_row    <= '0;
      out_data   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          set_q <= '0;
          way_q <= '0;
          row_q <= '0;
          if (start) begin
            busy     <= 1'b1;
            tag_en   <= 1'b1;
            tag_addr <= '0;
            state    <= TAG_REQ;
          end
        end
        TAG_REQ: begin
          tag_en <= 1'b0;
          state  <= TAG_RSP;
        end
        TAG_RSP: begin
          tag_buf    <= tag_rdata;
          out_valid  <= 1'b1;
          out_is_tag <= 1'b1;
          out_set    <= set_q;
          out_way    <= '0;
          out_row    <= '0;
          out_data   <= tag_field(tag_rdata, '0);
          state      <= TAG_EMIT;
        end
        TAG_EMIT: begin
          if (fire) begin
            if (!last_way) begin
              way_q    <= way_nx;
              out_way  <= way_nx;
              out_data <= tag_field(tag_buf, way_nx);
            end else begin
              way_q     <= '0;
              row_q     <= '0;
              out_valid <= 1'b0;
              data_en   <= 1'b1;
              data_addr <= row_addr(set_q, '0);
              state     <= DATA_REQ;
            end
          end
        end
        DATA_REQ: begin
          data_en <= 1'b0;
          state   <= DATA_RSP;
        end
        DATA_RSP: begin
          data_buf   <= data_rdata;
          out_valid  <= 1'b1;
          out_is_tag <= 1'b0;
          out_set    <= set_q;
          out_way    <= '0;
          out_row    <= row_q;
          out_data   <= data_rdata[0 +: DW];
          state      <= DATA_EMIT;
        end
        DATA_EMIT: begin
          if (fire) begin
            if (!last_way) begin
              way_q    <= way_nx;
              out_way  <= way_nx;
              out_data <= data_buf[way_nx*DW +: DW];
            end else begin
              way_q     <= '0;
              out_valid <= 1'b0;
              if (!last_row) begin
                row_q     <= row_q + RW'(1);
                data_en   <= 1'b1;
                data_addr <= row_addr(set_q, row_q + RW'(1));
                state     <= DATA_REQ;
              end else begin
                row_q <= '0;
                if (last_set) begin
                  done  <= 1'b1;
                  state <= DONE;
                end else begin
                  set_q    <= set_q + SW'(1);
                  tag_en   <= 1'b1;
                  tag_addr <= set_q + SW'(1);
                  state    <= TAG_REQ;
                end
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_state_dumper.sv
// Directed bench for dcache_state_dumper: default-size dump scenarios plus a one-set, one-row instance.
module tb_dcache_state_dumper;

  typedef struct packed {
    logic        is_tag;
    logic [5:0]  set;
    logic [1:0]  way;
    logic [2:0]  row;
    logic [63:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-size DUT
  logic         start = 1'b0, out_ready = 1'b0;
  logic         busy, done, tag_en, data_en, out_valid, out_is_tag;
  logic [5:0]   tag_addr, out_set;
  logic [8:0]   data_addr;
  logic [87:0]  tag_rdata;
  logic [255:0] data_rdata;
  logic [1:0]   out_way;
  logic [2:0]   out_row;
  logic [63:0]  out_data;

  dcache_state_dumper dut (
    .clk(clk), .reset(rst), .start(start), .busy(busy), .done(done),
    .tag_en(tag_en), .tag_addr(tag_addr), .tag_rdata(tag_rdata),
    .data_en(data_en), .data_addr(data_addr), .data_rdata(data_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_tag(out_is_tag),
    .out_set(out_set), .out_way(out_way), .out_row(out_row), .out_data(out_data)
  );

  // Single-set, single-row DUT
  logic         s_start = 1'b0, s_out_ready = 1'b0;
  logic         s_busy, s_done, s_tag_en, s_data_en, s_out_valid, s_out_is_tag;
  logic [0:0]   s_tag_addr, s_data_addr, s_out_set, s_out_row;
  logic [87:0]  s_tag_rdata;
  logic [255:0] s_data_rdata;
  logic [1:0]   s_out_way;
  logic [63:0]  s_out_data;

  dcache_state_dumper #(.SETS(1), .ROWS(1)) dut_small (
    .clk(clk), .reset(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .tag_en(s_tag_en), .tag_addr(s_tag_addr), .tag_rdata(s_tag_rdata),
    .data_en(s_data_en), .data_addr(s_data_addr), .data_rdata(s_data_rdata),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_is_tag(s_out_is_tag),
    .out_set(s_out_set), .out_way(s_out_way), .out_row(s_out_row), .out_data(s_out_data)
  );

  function automatic logic [21:0] tag_pat(input int s, input int w);
    return 22'((s << 4) | w);
  endfunction

  // SRAM models, one-cycle read latency
  always @(posedge clk) begin
    if (tag_en)
      for (int w = 0; w < 4; w++) tag_rdata[w*22 +: 22] <= tag_pat(int'(tag_addr), w);
    if (data_en)
      for (int l = 0; l < 32; l++) data_rdata[l*8 +: 8] <= 8'((int'(data_addr) + l) & 255);
    if (s_tag_en)
      for (int w = 0; w < 4; w++) s_tag_rdata[w*22 +: 22] <= tag_pat(int'(s_tag_addr), w);
    if (s_data_en)
      for (int l = 0; l < 32; l++) s_data_rdata[l*8 +: 8] <= 8'((int'(s_data_addr) + l) & 255);
  end

  function automatic rec_t exp_rec(input int k, input int rows);
    rec_t e;
    int per, s, r, d, a;
    per = 4 * (1 + rows);
    s = k / per;
    r = k % per;
    e = '0;
    e.set = 6'(s);
    if (r < 4) begin
      e.is_tag = 1'b1;
      e.way = 2'(r);
      e.data = 64'(tag_pat(s, r));
    end else begin
      d = r - 4;
      e.row = 3'(d / 4);
      e.way = 2'(d % 4);
      a = s * rows + d / 4;
      for (int b = 0; b < 8; b++) e.data[b*8 +: 8] = 8'((a + (d % 4) * 8 + b) & 255);
    end
    return e;
  endfunction

  int n_assert = 0;
  int n_fail = 0;
  int proto_err, stall_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_dump(input int ready_pct, input int restart_at, input int reset_at,
                          output int done_cyc, output int nrec, output int first_ten,
                          output int first_val, output logic busy_after);
    int c, r, s;
    rec_t obs, prev;
    logic prev_stall, prev_ten, prev_den;
    done_cyc = -1; nrec = 0; first_ten = -1; first_val = -1; busy_after = 1'bx;
    prev = '0; prev_stall = 1'b0; prev_ten = 1'b0; prev_den = 1'b0;
    proto_err = 0; stall_err = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 40000) begin
      start = (c == restart_at);
      if (c == reset_at) begin
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tag_en", tag_en, 0);
        chk("rst_data_en", data_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      obs = {out_is_tag, out_set, out_way, out_row, out_data};
      if (tag_en && first_ten < 0) first_ten = c;
      if (out_valid && first_val < 0) first_val = c;
      s = nrec / 36;
      r = nrec % 36;
      if (tag_en && data_en) proto_err++;
      if ((tag_en && prev_ten) || (data_en && prev_den)) proto_err++;
      if (tag_en && (r != 0 || int'(tag_addr) != s)) proto_err++;
      if (data_en && (r < 4 || (r - 4) % 4 != 0 || int'(data_addr) != s * 8 + (r - 4) / 4))
        proto_err++;
      if (prev_stall && (!out_valid || obs !== prev)) stall_err++;
      if (done) begin
        done_cyc = c;
        @(posedge clk); #1;
        busy_after = busy;
        break;
      end
      out_ready = (int'($urandom_range(0, 99)) < ready_pct);
      if (out_valid && out_ready) begin
        chk("record", obs, exp_rec(nrec, 8));
        nrec++;
      end
      prev_stall = out_valid && !out_ready;
      prev = obs;
      prev_ten = tag_en;
      prev_den = data_en;
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    int dc, nr, ft, fv, sdone, sn, addr_err;
    logic ba;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_tag_en", tag_en, 0);
    chk("reset_data_en", data_en, 0);
    chk("reset_fields", {tag_addr, data_addr, out_is_tag, out_set, out_way, out_row, out_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full dump, out_ready tied high
    run_dump(100, -1, -1, dc, nr, ft, fv, ba);
    chk("full_done_cycle", dc, 3457);
    chk("full_records", nr, 2304);
    chk("full_busy_after_done", ba, 0);
    chk("full_first_tag_en", ft, 1);
    chk("full_first_valid", fv, 3);
    chk("full_protocol", proto_err, 0);
    repeat (3) @(posedge clk);
    #1;

    // start pulsed again while busy
    run_dump(100, 100, -1, dc, nr, ft, fv, ba);
    chk("restart_done_cycle", dc, 3457);
    chk("restart_records", nr, 2304);
    chk("restart_busy_after_done", ba, 0);
    chk("restart_protocol", proto_err, 0);
    repeat (3) @(posedge clk);
    #1;

    // Random backpressure, ready 30% of cycles
    run_dump(30, -1, -1, dc, nr, ft, fv, ba);
    chk("bp_done_seen", (dc > 3457), 1);
    chk("bp_records", nr, 2304);
    chk("bp_stall_stable", stall_err, 0);
    chk("bp_protocol", proto_err, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset during set 10 DATA_EMIT (row 0, way 1), then a fresh dump
    run_dump(100, -1, 550, dc, nr, ft, fv, ba);
    chk("midrst_records", nr, 365);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_idle_valid", out_valid, 0);
    run_dump(100, -1, -1, dc, nr, ft, fv, ba);
    chk("after_rst_done_cycle", dc, 3457);
    chk("after_rst_records", nr, 2304);
    repeat (3) @(posedge clk);
    #1;

    // Single set, single row instance
    sdone = -1; sn = 0; addr_err = 0;
    s_out_ready = 1'b1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if ((s_tag_en && s_tag_addr != 1'b0) || (s_data_en && s_data_addr != 1'b0)) addr_err++;
      if (s_tag_en && s_data_en) addr_err++;
      if (s_done && sdone < 0) sdone = c;
      if (s_out_valid) begin
        chk("small_record", {s_out_is_tag, 5'b0, s_out_set, s_out_way, 2'b0, s_out_row, s_out_data},
            exp_rec(sn, 1));
        sn++;
      end
      @(posedge clk); #1;
    end
    chk("small_records", sn, 8);
    chk("small_done_cycle", sdone, 13);
    chk("small_addr", addr_err, 0);
    chk("small_busy_idle", s_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
